// File: rtl/isram_boot_loader.sv
// Boot-time AHB-Lite master: loads a length-prefixed byte image into instruction SRAM.
// Define ISRAM_BOOT_CHECKSUM_EN to require a trailing 8-bit additive checksum byte.
module isram_boot_loader #(
    parameter int              AW        = 16,
    parameter logic [AW-1:0]   BASE_ADDR = {AW{1'b0}}
) (
    input  logic          HCLK,
    input  logic          HRESET,
    input  logic [7:0]    RX_DATA,
    input  logic          RX_VALID,
    output logic          RX_READY,
    output logic [AW-1:0] HADDR,
    output logic [1:0]    HTRANS,
    output logic          HWRITE,
    output logic [2:0]    HSIZE,
    output logic [31:0]   HWDATA,
    input  logic          HREADY,
    input  logic          HRESP,
    output logic          CPU_HOLD,
    output logic          BOOT_DONE,
    output logic          BOOT_ERR
);

    typedef enum logic [3:0] {
        S_IDLE  = 4'd0,
        S_LEN0  = 4'd1,
        S_LEN1  = 4'd2,
        S_BYTES = 4'd3,
        S_ADDR  = 4'd4,
        S_DATA  = 4'd5,
`ifdef ISRAM_BOOT_CHECKSUM_EN
        S_CSUM  = 4'd6,
`endif
        S_DONE  = 4'd7,
        S_ERROR = 4'd8
    } state_t;

    // The image may not exceed the word capacity of the SRAM window.
    localparam logic [32:0] MAX_WORDS = 33'd1 << (AW - 2);
`ifdef ISRAM_BOOT_CHECKSUM_EN
    localparam state_t S_FIN = S_CSUM;
`else
    localparam state_t S_FIN = S_DONE;
`endif

    state_t        state_r;
    state_t        state_s;
    logic [7:0]    cnt_lo_r;
    logic [15:0]   cnt_r;
    logic [15:0]   idx_r;
    logic [1:0]    bsel_r;
    logic [31:0]   word_r;
    logic [AW-1:0] addr_r;
`ifdef ISRAM_BOOT_CHECKSUM_EN
    logic [7:0]    sum_r;
`endif
    logic          rx_ready_r;
    logic [1:0]    htrans_r;
    logic [AW-1:0] haddr_r;
    logic          hwrite_r;
    logic [31:0]   hwdata_r;
    logic          cpu_hold_r;
    logic          boot_done_r;
    logic          boot_err_r;

    logic          acc_s;
    logic [15:0]   cnt_s;
    logic          too_big_s;
    logic          last_s;

    assign acc_s     = RX_VALID && rx_ready_r;
    assign cnt_s     = {RX_DATA, cnt_lo_r};
    assign too_big_s = ({17'd0, cnt_s} > MAX_WORDS);
    assign last_s    = ((idx_r + 16'd1) == cnt_r);

    // Next-state decode for the image parser and bus sequencer.
    always_comb begin
        state_s = state_r;
        case (state_r)
            S_IDLE: state_s = S_LEN0;
            S_LEN0: begin
                if (acc_s) state_s = S_LEN1;
                else       state_s = S_LEN0;
            end
            S_LEN1: begin
                if (!acc_s)                state_s = S_LEN1;
                else if (too_big_s)        state_s = S_ERROR;
                else if (cnt_s == 16'd0)   state_s = S_FIN;
                else                       state_s = S_BYTES;
            end
            S_BYTES: begin
                if (acc_s && (bsel_r == 2'd3)) state_s = S_ADDR;
                else                           state_s = S_BYTES;
            end
            S_ADDR: begin
                if (HREADY) state_s = S_DATA;
                else        state_s = S_ADDR;
            end
            S_DATA: begin
                if (HRESP)       state_s = S_ERROR;
                else if (!HREADY) state_s = S_DATA;
                else if (last_s) state_s = S_FIN;
                else             state_s = S_BYTES;
            end
`ifdef ISRAM_BOOT_CHECKSUM_EN
            S_CSUM: begin
                if (!acc_s)                state_s = S_CSUM;
                else if (RX_DATA == sum_r) state_s = S_DONE;
                else                       state_s = S_ERROR;
            end
`endif
            S_DONE:  state_s = S_DONE;
            S_ERROR: state_s = S_ERROR;
            default: state_s = S_ERROR;
        endcase
    end

    // State, count, word packing and address tracking.
    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            state_r  <= S_IDLE;
            cnt_lo_r <= 8'd0;
            cnt_r    <= 16'd0;
            idx_r    <= 16'd0;
            bsel_r   <= 2'd0;
            word_r   <= 32'd0;
            addr_r   <= BASE_ADDR;
`ifdef ISRAM_BOOT_CHECKSUM_EN
            sum_r    <= 8'd0;
`endif
        end else begin
            state_r <= state_s;
            if ((state_r == S_LEN0) && acc_s) begin
                cnt_lo_r <= RX_DATA;
            end
            if ((state_r == S_LEN1) && acc_s) begin
                cnt_r  <= cnt_s;
                idx_r  <= 16'd0;
                bsel_r <= 2'd0;
                addr_r <= BASE_ADDR;
`ifdef ISRAM_BOOT_CHECKSUM_EN
                sum_r  <= 8'd0;
`endif
            end
            if ((state_r == S_BYTES) && acc_s) begin
                case (bsel_r)
                    2'd0:    word_r[7:0]   <= RX_DATA;
                    2'd1:    word_r[15:8]  <= RX_DATA;
                    2'd2:    word_r[23:16] <= RX_DATA;
                    default: word_r[31:24] <= RX_DATA;
                endcase
                bsel_r <= bsel_r + 2'd1;
`ifdef ISRAM_BOOT_CHECKSUM_EN
                sum_r  <= sum_r + RX_DATA;
`endif
            end
            if ((state_r == S_DATA) && HREADY && !HRESP) begin
                idx_r  <= idx_r + 16'd1;
                addr_r <= addr_r + {{(AW-3){1'b0}}, 3'b100};
            end
        end
    end

    // Outputs registered from the next state so they line up with state_r.
    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            rx_ready_r  <= 1'b0;
            htrans_r    <= 2'b00;
            haddr_r     <= {AW{1'b0}};
            hwrite_r    <= 1'b0;
            hwdata_r    <= 32'd0;
            cpu_hold_r  <= 1'b1;
            boot_done_r <= 1'b0;
            boot_err_r  <= 1'b0;
        end else begin
            rx_ready_r  <= (state_s == S_LEN0) || (state_s == S_LEN1) ||
`ifdef ISRAM_BOOT_CHECKSUM_EN
                           (state_s == S_CSUM) ||
`endif
                           (state_s == S_BYTES);
            htrans_r    <= (state_s == S_ADDR) ? 2'b10 : 2'b00;
            hwrite_r    <= (state_s == S_ADDR);
            if (state_s == S_ADDR) begin
                haddr_r <= addr_r;
            end
            if (state_s == S_DATA) begin
                hwdata_r <= word_r;
            end
            cpu_hold_r  <= (state_s != S_DONE);
            boot_done_r <= (state_s == S_DONE);
            boot_err_r  <= (state_s == S_ERROR);
        end
    end

    assign RX_READY  = rx_ready_r;
    assign HTRANS    = htrans_r;
    assign HADDR     = haddr_r;
    assign HWRITE    = hwrite_r;
    assign HSIZE     = 3'b010;
    assign HWDATA    = hwdata_r;
    assign CPU_HOLD  = cpu_hold_r;
    assign BOOT_DONE = boot_done_r;
    assign BOOT_ERR  = boot_err_r;

endmodule
